// File: rtl/control_unit_fsm.sv
// Sequencing FSM for a radix-4 SRT divider: normalize, iterate 4 digits, correct, denormalize.
// All datapath controls are combinational from the current state and inputs.
module control_unit_fsm (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        beginSignal,
   input  logic        b7,
   input  logic [3:0]  b,
   input  logic [5:0]  msbp,
   input  logic [1:0]  cnt1,
   input  logic        p8,
   input  logic [2:0]  cnt2,
   output logic        endSignal,
   output logic [16:0] control_signals
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StNorm,
      StShift,
      StOp,
      StCorr,
      StDenorm,
      StDone
   } state_e;

   state_e state_q, state_d;

   // Compare 2p against multiples of b in 8-bit signed arithmetic: 2p spans -64..62.
   logic signed [7:0] p2, b1, b3, nb1, nb3;
   logic              sel_add, sel_sub, sel_two;

   always_comb begin
      p2  = {msbp[5], msbp, 1'b0};
      b1  = {4'b0000, b};
      b3  = b1 + b1 + b1;
      nb1 = -b1;
      nb3 = -b3;
      sel_sub = (p2 >= b1);
      sel_add = (p2 < nb1);
      sel_two = (p2 >= b3) || (p2 < nb3);
   end

   always_comb begin
      state_d         = state_q;
      control_signals = 17'h0;
      endSignal       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (beginSignal) state_d = StLoad;
         end
         StLoad: begin
            control_signals[3:0] = 4'b1111;
            state_d              = StNorm;
         end
         StNorm: begin
            if (!b7 && (cnt2 != 3'd7)) begin
               control_signals[4] = 1'b1;
               control_signals[5] = 1'b1;
               control_signals[6] = 1'b1;
            end else begin
               state_d = StShift;
            end
         end
         StShift: begin
            control_signals[7] = 1'b1;
            state_d            = StOp;
         end
         StOp: begin
            control_signals[8]  = sel_add;
            control_signals[9]  = sel_sub;
            control_signals[10] = sel_two;
            control_signals[11] = 1'b1;
            state_d             = (cnt1 == 2'd3) ? StCorr : StShift;
         end
         StCorr: begin
            control_signals[12] = p8;
            control_signals[13] = p8;
            state_d             = StDenorm;
         end
         StDenorm: begin
            if (cnt2 != 3'd0) begin
               control_signals[14] = 1'b1;
               control_signals[15] = 1'b1;
            end else begin
               state_d = StDone;
            end
         end
         StDone: begin
            control_signals[16] = 1'b1;
            endSignal           = 1'b1;
            state_d             = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_b) state_q <= StIdle;
      else        state_q <= state_d;
   end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Bench for control_unit_fsm: a directed divide run followed by randomized inputs, all
// checked every cycle against a phase-name reference model.
module tb_control_unit_fsm;

   logic        clk = 1'b0;
   logic        rst_b, beginSignal, b7, p8;
   logic [3:0]  b;
   logic [5:0]  msbp;
   logic [1:0]  cnt1;
   logic [2:0]  cnt2;
   logic        endSignal;
   logic [16:0] control_signals;

   int n_checks = 0;
   int n_errors = 0;

   string phase = "UNKNOWN";

   control_unit_fsm dut (
      .clk             (clk),
      .rst_b           (rst_b),
      .beginSignal     (beginSignal),
      .b7              (b7),
      .b               (b),
      .msbp            (msbp),
      .cnt1            (cnt1),
      .p8              (p8),
      .cnt2            (cnt2),
      .endSignal       (endSignal),
      .control_signals (control_signals)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   // Expected controls and next phase from the divider's sequencing rules.
   task automatic model(output logic [16:0] ctl, output logic fin, output string nxt);
      int p, tp, bb;
      ctl = 17'h0;
      fin = 1'b0;
      nxt = phase;
      case (phase)
         "IDLE": if (beginSignal) nxt = "LOAD";
         "LOAD": begin
            for (int i = 0; i < 4; i++) ctl[i] = 1'b1;
            nxt = "NORM";
         end
         "NORM": begin
            if (b7 || cnt2 == 3'd7) nxt = "SHIFT";
            else begin ctl[4] = 1'b1; ctl[5] = 1'b1; ctl[6] = 1'b1; end
         end
         "SHIFT": begin ctl[7] = 1'b1; nxt = "OP"; end
         "OP": begin
            p  = int'(msbp);
            if (p >= 32) p = p - 64;
            tp = 2 * p;
            bb = int'(b);
            if (tp >= 3 * bb)       begin ctl[9] = 1'b1; ctl[10] = 1'b1; end
            else if (tp >= bb)      ctl[9] = 1'b1;
            else if (tp >= -bb)     ctl = ctl;
            else if (tp >= -3 * bb) ctl[8] = 1'b1;
            else                    begin ctl[8] = 1'b1; ctl[10] = 1'b1; end
            ctl[11] = 1'b1;
            nxt = (cnt1 == 2'd3) ? "CORR" : "SHIFT";
         end
         "CORR": begin
            if (p8) begin ctl[12] = 1'b1; ctl[13] = 1'b1; end
            nxt = "DENORM";
         end
         "DENORM": begin
            if (cnt2 != 3'd0) begin ctl[14] = 1'b1; ctl[15] = 1'b1; end
            else nxt = "DONE";
         end
         "DONE": begin ctl[16] = 1'b1; fin = 1'b1; nxt = "IDLE"; end
         default: nxt = phase;
      endcase
      if (!rst_b) nxt = "IDLE";
   endtask

   task automatic cyc(input logic rb, input logic bg, input logic vb7, input logic [3:0] vb,
                      input logic [5:0] vp, input logic [1:0] c1, input logic vp8,
                      input logic [2:0] c2);
      logic [16:0] ctl;
      logic        fin;
      string       nxt;
      @(negedge clk);
      rst_b = rb; beginSignal = bg; b7 = vb7; b = vb; msbp = vp; cnt1 = c1; p8 = vp8; cnt2 = c2;
      #1;
      model(ctl, fin, nxt);
      if (phase != "UNKNOWN") begin
         check_eq({phase, "_ctrl"}, control_signals, ctl);
         check_eq({phase, "_end"}, {16'h0, endSignal}, {16'h0, fin});
      end
      @(posedge clk);
      phase = nxt;
   endtask

   initial begin
      // reset, then a full directed divide with b=12
      cyc(0, 0, 0, 4'd0, 6'd0, 2'd0, 0, 3'd0);
      cyc(0, 1, 0, 4'd0, 6'd0, 2'd0, 0, 3'd0);
      cyc(1, 0, 0, 4'd0, 6'd0, 2'd0, 0, 3'd0);   // IDLE, all zero
      cyc(1, 1, 0, 4'd0, 6'd0, 2'd0, 0, 3'd0);   // start
      cyc(1, 1, 0, 4'd0, 6'd0, 2'd0, 0, 3'd0);   // LOAD
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'd6, 6'd0, 2'd0, 0, 3'(i));
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 0, 3'd3);  // NORM exit
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 0, 3'd3);  // SHIFT
      cyc(1, 0, 1, 4'd12, 6'b000001, 2'd0, 0, 3'd3);
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd1, 0, 3'd3);
      cyc(1, 0, 1, 4'd12, 6'b110100, 2'd1, 0, 3'd3);
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd2, 0, 3'd3);
      cyc(1, 0, 1, 4'd12, 6'b010010, 2'd2, 0, 3'd3);
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd3, 0, 3'd3);
      cyc(1, 0, 1, 4'd12, 6'b101000, 2'd3, 0, 3'd3);  // -24: q=-2, exit loop
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 1, 3'd3);       // CORR with p8
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 0, 3'd2);
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 0, 3'd1);
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 0, 3'd0);
      cyc(1, 1, 1, 4'd12, 6'd0, 2'd0, 0, 3'd0);  // DONE with begin held
      cyc(1, 1, 1, 4'd12, 6'd0, 2'd0, 0, 3'd0);  // IDLE one cycle
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 0, 3'd0);  // LOAD
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 0, 3'd0);  // NORM
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 0, 3'd0);  // SHIFT
      cyc(0, 0, 1, 4'd12, 6'd9, 2'd0, 0, 3'd0);  // reset in OP
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 0, 3'd0);
      cyc(1, 0, 1, 4'd12, 6'd0, 2'd0, 0, 3'd0);
      // randomized phase
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 99) >= 2), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0), 4'($urandom), 6'($urandom), 2'($urandom),
             1'($urandom), 3'($urandom));
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/control_unit_fsm.md
CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-low, with ports named as follows:
- clk  input  1  rising-edge clock
- rst_b  input  1  reset, synchronous, active-low
REQ-002 The block SHALL have these further ports:
- beginSignal  input  1  start request; sampled only in IDLE
- b7  input  1  MSB of divisor register B; 1 = normalized
- b  input  4  top 4 bits of normalized divisor; unsigned 8..15
- msbp  input  6  top 6 bits of partial remainder P; two's complement
- cnt1  input  2  iteration counter value, from datapath
- p8  input  1  sign bit of P; 1 = negative
- cnt2  input  3  normalization shift count, from datapath
- endSignal  output  1  completion pulse
- control_signals  output  17  datapath controls c[16:0]
REQ-003 control_signals bits SHALL be:
- c0 load A (dividend); c1 load B (divisor); c2 clear P; c3 clear cnt1 and cnt2
- c4 shift P:A left 1; c5 shift B left 1; c6 increment cnt2
- c7 shift P:A and Q left 2
- c8 P+=operand and Q-=digit; c9 P-=operand and Q+=digit; c10 operand=2B and digit=2 (else operand=B, digit=1)
- c11 increment cnt1; c12 P+=B (correction); c13 Q-=1
- c14 arithmetic shift P right 1; c15 decrement cnt2; c16 load result registers

Function
REQ-004 The block SHALL implement an FSM with eight states: IDLE, LOAD, NORM, SHIFT, OP, CORR, DENORM, DONE.
REQ-005 The next-state register SHALL update on the rising clk edge; control_signals and endSignal SHALL be combinational from the current state and current inputs.
REQ-006 IDLE: beginSignal=1 -> LOAD, else stay; all outputs 0.
REQ-007 LOAD: assert c0, c1, c2 and c3; -> NORM.
REQ-008 NORM, b7=0 and cnt2!=7: assert c4, c5 and c6; stay in NORM.
REQ-009 NORM, b7=1 or cnt2==7: no controls; -> SHIFT. This bounds normalization to 7 shifts, so a zero divisor still terminates; its result is undefined.
REQ-010 SHIFT: assert c7; -> OP.
REQ-011 OP SHALL select digit q from b and p = signed(msbp):
- q=+2 if 2p >= 3b
- q=+1 if b <= 2p < 3b
- q=0 if -b <= 2p < b
- q=-1 if -3b <= 2p < -b
- q=-2 if 2p < -3b
REQ-012 OP SHALL drive the digit as follows:
- q=+1: c9
- q=+2: c9 and c10
- q=-1: c8
- q=-2: c8 and c10
- q=0: neither c8 nor c9
REQ-013 OP SHALL always assert c11; cnt1==3 -> CORR, else -> SHIFT. This gives exactly 4 radix-4 iterations.
REQ-014 CORR: p8=1 asserts c12 and c13; p8=0 asserts nothing; -> DENORM.
REQ-015 DENORM, cnt2!=0: assert c14 and c15; stay in DENORM.
REQ-016 DENORM, cnt2==0: no controls; -> DONE.
REQ-017 DONE: assert c16 and endSignal=1 for exactly one cycle; -> IDLE.
REQ-018 c8 and c9 SHALL never be asserted together; no two states share an active-control pattern except all-zero.
REQ-019 beginSignal outside IDLE SHALL be ignored; holding beginSignal high in DONE SHALL start a new operation only after one cycle in IDLE.

Reset
REQ-020 rst_b=0 at a rising edge SHALL force IDLE from any state, including mid-operation; the next operation requires a fresh beginSignal.
REQ-021 While in IDLE after reset: control_signals = 17'h0, endSignal = 0.

Verification
REQ-022 Start and load: beginSignal=1 for one edge in IDLE -> next cycle c0..c3 = 1; following cycle state NORM.
REQ-023 Normalization: b7=0 for 3 cycles, then 1 -> c4, c5, c6 asserted for exactly 3 cycles, then c7 asserted.
REQ-024 Digit selection with b=12:
- msbp=6'b000001 -> no c8/c9
- msbp=6'b110100 (-12) -> c8 only
- msbp=6'b010010 (+18) -> c9 and c10
REQ-025 Loop exit: cnt1 held 0..2 -> OP returns to SHIFT; cnt1=3 in OP -> CORR next.
REQ-026 Correction and denormalization:
- p8=1 in CORR -> c12 and c13 for one cycle
- then cnt2=2,1,0 -> c14 and c15 for 2 cycles
- then endSignal=1 and c16=1 for one cycle, then IDLE with all outputs 0
REQ-027 Reset mid-run: rst_b=0 during OP -> next edge IDLE, outputs 0; beginSignal=0 keeps the block in IDLE.
